// File: rtl/signal_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : signal_feeder_fifo
//  Purpose  : First-word-fall-through buffer feeding the signal manager.
//             Producer words are queued in a circular register array and
//             presented on data/valid. One word is popped per manager ack.
//             Writes into a full buffer are dropped, and the drops are
//             recorded in a sticky overflow flag and a saturating counter.
//  Revision : 1.0 - initial release
// ============================================================================
module signal_feeder_fifo #(
    parameter int WIDTH = 32,   // must match the manager's data width
    parameter int DEPTH = 8     // power of two, at least 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    input  logic                     ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] C_COUNT_ONE = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
    localparam logic [7:0]    C_DROP_MAX  = 8'hFF;

    // Storage and bookkeeping registers
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]    count_q,      count_d;
    logic             overflow_q,   overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;

    // Event decodes, all based on the pre-edge (registered) occupancy
    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status flags come from the registered count only, so wr_en/wr_data
    // never reach valid/data combinationally.
    assign w_full  = (count_q == C_DEPTH);
    assign w_valid = (count_q != '0);

    // Full is sampled before the edge: a pop in the same cycle does not
    // make room for the write.
    assign w_push = wr_en && !w_full;
    assign w_drop = wr_en &&  w_full;
    assign w_pop  = ack   &&  w_valid;

    // Next-state computation for pointers, occupancy and drop statistics
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        // Simultaneous push and pop leave occupancy unchanged
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_COUNT_ONE;
            2'b01:   count_d = count_q - C_COUNT_ONE;
            default: count_d = count_q;
        endcase

        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != C_DROP_MAX) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // Control state update with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Word storage; contents are not cleared by reset, only guarded from it
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head word is a plain register read, stable through the ack cycle,
    // and forced to zero whenever nothing valid is held.
    assign data       = w_valid ? mem_q[rd_ptr_q] : '0;
    assign valid      = w_valid;
    assign full       = w_full;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: doc/signal_feeder_fifo.md
# signal_feeder_fifo

First-word-fall-through buffer that sits directly upstream of the signal manager stage. It accepts words from a producer write port and presents them on a `data`/`valid` pair that connects directly to the manager's `data`/`valid` inputs. It pops one word on each `ack` that the manager returns (the manager raises `ack` when `valid && ready`). It absorbs producer bursts while the manager's `ready` is low, and reports occupancy and overflow.

## Interface
- Reset is synchronous and active-high; one clock.
- Parameters:
- WIDTH, 32, data word width in bits; must equal the manager's data width.
- DEPTH, 8, storage depth in words; power of 2, ≥ 2.
- Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  producer write strobe.
- wr_data  input  WIDTH  producer write word.
- full  output  1  high when count == DEPTH.
- valid  output  1  head word available; connects to the manager's valid input.
- data  output  WIDTH  head word; connects to the manager's data input.
- ack  input  1  consumer accepted head this cycle; driven from the manager's ack output.
- count  output  $clog2(DEPTH)+1  words currently stored.
- overflow  output  1  sticky: a write was dropped since reset.
- drop_count  output  8  number of dropped writes, saturating at 255.

## Operation
- Storage is a circular register array mem[DEPTH] with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- count is a separate register; pointer equality alone is never used to derive full or empty.
- Push condition: wr_en && !full. The word is stored at mem[wr_ptr] and wr_ptr increments.
- Pop condition: ack && valid. rd_ptr increments.
- ack while valid is low is ignored: no pointer or count change.
- count next value:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop, or when neither occurs.
- Drop condition: wr_en && full.
  - The word is discarded; no state other than overflow and drop_count changes.
  - overflow is set and held until rst.
  - drop_count increments, saturating at 255.
- Full, with simultaneous wr_en and pop: the write is still dropped, because full is sampled pre-edge. The pop proceeds and count ends at DEPTH−1. The producer must not rely on same-cycle freeing.
- Empty, with simultaneous wr_en and ack: push only; ack is ignored; count ends at 1.
- valid = (count != 0), combinational from registered count.
- full = (count == DEPTH), combinational from registered count.
- data = mem[rd_ptr] when valid, otherwise all zeros. data therefore never shows stale contents while valid is low.
- Word order is strictly FIFO; no word is duplicated or skipped across pointer wrap.

## Timing
- Reset, at the first rising edge with rst high:
  - wr_ptr, rd_ptr, count all 0;
  - overflow 0, drop_count 0.
- Outputs after reset:
  - valid 0, data 0, full 0, count 0, overflow 0, drop_count 0.
  - mem contents are not cleared and are don't-care.
- rst has priority over wr_en and ack in the same cycle. Asserting rst mid-operation discards all stored words; valid is low the cycle after.
- Write-to-valid latency: a push at edge N gives valid high and data = that word after edge N, i.e. visible in cycle N+1 when the FIFO was empty.
- Pop-to-next-head: a pop at edge N exposes the next word (or valid low) in cycle N+1.
- The manager captures data at the same edge where ack is high, so the head must remain stable throughout the ack cycle. The head is a pure register read, which satisfies this.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy 1..DEPTH−1.
- No combinational path from wr_en or wr_data to valid or data. ack reaches only registered state.

## Test plan
- Reset then idle, DEPTH=4:
  - rst for 2 cycles, then no stimulus.
  - Required: valid=0, data=0, count=0, full=0, overflow=0, drop_count=0 for 10 cycles.
  - Also drive ack=1 while empty: count stays 0.
- Fill and drain, DEPTH=4:
  - Write 0xA0000001..0xA0000004 on consecutive cycles with ack=0.
  - Required: count=4, full=1.
  - Then hold ack=1: data reads 0xA0000001..0xA0000004 on 4 consecutive cycles, then valid=0, data=0.
- Overflow, DEPTH=4:
  - Full FIFO; write 0xDEAD0000 for 3 cycles with ack=0.
  - Required: count=4, overflow=1, drop_count=3.
  - Drained sequence excludes 0xDEAD0000.
  - Drop_count saturation: 300 dropped writes give drop_count=255.
- Simultaneous events:
  - At count=2, wr_en and ack in the same cycle: count stays 2 and order is preserved.
  - At count=4, wr_en and ack in the same cycle: count=3, and the write is dropped (drop_count+1).
  - At count=0, wr_en and ack in the same cycle: count=1.
- Wrap and streaming, DEPTH=4:
  - 1000 random writes; ack driven by a random ready, connected to the manager as valid && ready.
  - Required: the scoreboard sees exact FIFO order across wraps, and the manager's processed_data matches each accepted word.
- Reset mid-stream:
  - At count=3, assert rst for 1 cycle together with wr_en and ack.
  - Required: the next cycle shows count=0, valid=0, overflow=0.
  - A subsequent write of 0x12345678 appears as data one cycle later.
